// File: rtl/apb_slave_if.sv
`timescale 1ns/1ps
// APB3 slave front-end driving a single-cycle memory request port, with address-window check and wait states.
// Optional macro APB_SLV_ALIGN_CHK_EN: reject accesses with paddr[1:0] != 0 as errors.
module apb_slave_if #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           SIZE_BYTES  = 4096,
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    // One extra bit keeps the window compare free of wrap-around near the top of the address space.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(SIZE_BYTES);
    localparam logic [3:0]          WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic                    setup_seen_q;
    logic [3:0]              wait_cnt_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;
    logic                    mem_valid_q;
    logic                    mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_din_q;

    logic [ADDR_WIDTH:0]     paddr_ext;
    logic [ADDR_WIDTH:0]     offset_d;
    logic [ADDR_WIDTH-1:0]   word_idx_d;
    logic                    range_err;
    logic                    align_err;
    logic                    start;
    logic                    unused_offset_bits;

    assign paddr_ext          = {1'b0, paddr};
    assign offset_d           = paddr_ext - BASE_EXT;
    assign word_idx_d         = {2'b00, offset_d[ADDR_WIDTH-1:2]};
    assign unused_offset_bits = ^{offset_d[ADDR_WIDTH], offset_d[1:0]};
    assign range_err          = (paddr_ext < BASE_EXT) || (paddr_ext >= LIMIT_EXT);

`ifdef APB_SLV_ALIGN_CHK_EN
    assign align_err = (paddr[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    // A start needs a setup cycle immediately before, so a held access phase after RESP is ignored.
    assign start = (state_q == S_IDLE) && psel && penable && setup_seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            setup_seen_q <= 1'b0;
            wait_cnt_q   <= 4'd0;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_wr_rd_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            setup_seen_q <= psel & ~penable;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            mem_valid_q  <= 1'b0;

            if ((state_q != S_IDLE) && !psel) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (range_err || align_err) begin
                                state_q   <= S_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b1;
                                prdata_q  <= '0;
                            end else begin
                                // The memory-side registers double as the latched request.
                                mem_wr_rd_q <= pwrite;
                                mem_addr_q  <= word_idx_d;
                                mem_din_q   <= pwdata;
                                if (WAIT_STATES > 0) begin
                                    state_q    <= S_WAIT;
                                    wait_cnt_q <= WAIT_INIT;
                                end else begin
                                    state_q     <= S_ISSUE;
                                    mem_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt_q == 4'd0) begin
                            state_q     <= S_ISSUE;
                            mem_valid_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                    S_ISSUE: begin
                        if (mem_wr_rd_q) begin
                            state_q  <= S_RESP;
                            pready_q <= 1'b1;
                        end else begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        prdata_q <= mem_dout;
                        state_q  <= S_RESP;
                        pready_q <= 1'b1;
                    end
                    S_RESP: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign mem_valid = mem_valid_q;
    assign mem_wr_rd = mem_wr_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule
